// File: rtl/lab4_sys_mem_arbiter.sv
// Round-robin N-port memory arbiter: merges cache request streams onto one 16B memory port and
// routes in-order responses back through a source-ID FIFO. Optional stats: LAB4_SYS_MEM_ARBITER_STATS_EN.
package lab4_sys_mem_arbiter_pkg;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

endpackage

module lab4_sys_mem_arbiter
    import lab4_sys_mem_arbiter_pkg::*;
#(
    parameter int p_num_ports       = 2,
    parameter int p_max_outstanding = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  mem_req_16B_t           in_req_msg [p_num_ports],
    input  logic [p_num_ports-1:0] in_req_val,
    output logic [p_num_ports-1:0] in_req_rdy,
    output mem_resp_16B_t          in_resp_msg [p_num_ports],
    output logic [p_num_ports-1:0] in_resp_val,
    input  logic [p_num_ports-1:0] in_resp_rdy,
    output mem_req_16B_t           mem_req_msg,
    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    input  mem_resp_16B_t          mem_resp_msg,
    input  logic                   mem_resp_val,
    output logic                   mem_resp_rdy,
    output logic [p_num_ports-1:0] stats_grant,
    output logic [31:0]            stats_conflicts
);

    localparam int ID_W  = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;
    localparam int IDX_W = ID_W + 1;
    localparam int PTR_W = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
    localparam int CNT_W = $clog2(p_max_outstanding + 1);

    logic [ID_W-1:0]  rr;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  head;
    logic             any_val;
    logic             full;
    logic             empty;
    logic             req_fire;
    logic             resp_fire;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ID_W-1:0]  src_ids [p_max_outstanding];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(p_max_outstanding - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // First valid port at or after rr, wrapping modulo p_num_ports.
    always_comb begin : rr_pick
        logic [IDX_W-1:0] idx;
        idx     = '0;
        grant   = rr;
        any_val = 1'b0;
        for (int k = 0; k < p_num_ports; k++) begin
            idx = {1'b0, rr} + IDX_W'(k);
            if (idx >= IDX_W'(p_num_ports)) idx = idx - IDX_W'(p_num_ports);
            if (!any_val && in_req_val[idx[ID_W-1:0]]) begin
                any_val = 1'b1;
                grant   = idx[ID_W-1:0];
            end
        end
    end

    // Full depends only on the registered count, so no mem_resp_* to in_req_rdy path exists.
    assign full        = (count == CNT_W'(p_max_outstanding));
    assign empty       = (count == '0);
    assign head        = src_ids[rd_ptr];
    assign mem_req_val = reset & any_val & ~full;
    assign mem_req_msg = any_val ? in_req_msg[grant] : '0;
    assign req_fire    = mem_req_val & mem_req_rdy;
    assign mem_resp_rdy = reset & ~empty & in_resp_rdy[head];
    assign resp_fire   = mem_resp_val & mem_resp_rdy;

    always_comb begin
        in_req_rdy  = '0;
        in_resp_val = '0;
        for (int i = 0; i < p_num_ports; i++) begin
            in_resp_msg[i] = mem_resp_msg;
            if (grant == ID_W'(i)) in_req_rdy[i] = req_fire;
            if (head == ID_W'(i))  in_resp_val[i] = reset & mem_resp_val & ~empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (req_fire) begin
                wr_ptr <= next_ptr(wr_ptr);
                rr     <= (grant == ID_W'(p_num_ports - 1)) ? '0 : grant + ID_W'(1);
            end
            if (resp_fire) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(req_fire) - CNT_W'(resp_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) src_ids[wr_ptr] <= grant;
    end

`ifdef LAB4_SYS_MEM_ARBITER_STATS_EN
    logic [31:0] conflicts;

    always_ff @(posedge clk) begin
        if (!reset) begin
            conflicts <= '0;
        end else if ($countones(in_req_val) > 1) begin
            conflicts <= conflicts + 32'd1;
        end
    end

    always_comb begin
        stats_grant = '0;
        if (req_fire) stats_grant[grant] = 1'b1;
    end

    assign stats_conflicts = conflicts;
`else
    assign stats_grant     = '0;
    assign stats_conflicts = '0;
`endif

endmodule

// File: tb/tb_lab4_sys_mem_arbiter.sv
// Self-checking bench for lab4_sys_mem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-level model of the arbiter and a delayed in-order memory. Honours LAB4_SYS_MEM_ARBITER_STATS_EN.
module tb_lab4_sys_mem_arbiter;
    import lab4_sys_mem_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int MO = 4;
    localparam int RW = $bits(mem_resp_16B_t);

    logic          clk = 1'b0;
    logic          reset;
    mem_req_16B_t  in_req_msg [N];
    logic [N-1:0]  in_req_val;
    logic [N-1:0]  in_req_rdy;
    mem_resp_16B_t in_resp_msg [N];
    logic [N-1:0]  in_resp_val;
    logic [N-1:0]  in_resp_rdy;
    mem_req_16B_t  mem_req_msg;
    logic          mem_req_val;
    logic          mem_req_rdy;
    mem_resp_16B_t mem_resp_msg;
    logic          mem_resp_val;
    logic          mem_resp_rdy;
    logic [N-1:0]  stats_grant;
    logic [31:0]   stats_conflicts;

    always #5 clk = ~clk;

    lab4_sys_mem_arbiter #(.p_num_ports(N), .p_max_outstanding(MO)) dut (
        .clk(clk), .reset(reset),
        .in_req_msg(in_req_msg), .in_req_val(in_req_val), .in_req_rdy(in_req_rdy),
        .in_resp_msg(in_resp_msg), .in_resp_val(in_resp_val), .in_resp_rdy(in_resp_rdy),
        .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
        .stats_grant(stats_grant), .stats_conflicts(stats_conflicts)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Cache-side stimulus state and knobs.
    bit           pend [N];
    mem_req_16B_t pmsg [N];
    int           req_left [N];
    int           gen_pct [N];
    int           resp_pct [N];
    int           mem_rdy_pct;
    int           mem_delay;

    // Reference model: outstanding sources in issue order, memory queue, per-port expected responses.
    int           src_q [$];
    mem_req_16B_t mq_req [$];
    int           mq_due [$];
    logic [RW-1:0] exp_q0 [$];
    logic [RW-1:0] exp_q1 [$];
    int           m_rr;
    logic [31:0]  m_conf;

    int grant_log [$];
    int dut_resp_cnt [N];

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic mem_req_16B_t rand_req();
        mem_req_16B_t r;
        r.msg_type = 3'($urandom_range(1));
        r.opaque   = 8'($urandom);
        r.addr     = $urandom;
        r.len      = 4'($urandom);
        r.data     = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic mem_resp_16B_t mem_answer(input mem_req_16B_t r);
        mem_resp_16B_t a;
        a.msg_type = r.msg_type;
        a.opaque   = r.opaque;
        a.test     = 2'd0;
        a.len      = r.len;
        a.data     = r.data ^ {4{r.addr}};
        return a;
    endfunction

    function automatic bit idle();
        bit b;
        b = (src_q.size() == 0);
        for (int p = 0; p < N; p++) if (pend[p] || req_left[p] > 0) b = 0;
        return b;
    endfunction

    task automatic clear_model();
        src_q.delete();
        mq_req.delete();
        mq_due.delete();
        exp_q0.delete();
        exp_q1.delete();
        m_rr   = 0;
        m_conf = '0;
        for (int p = 0; p < N; p++) begin
            pend[p]     = 0;
            req_left[p] = 0;
        end
    endtask

    task automatic tick();
        int           g;
        int           h;
        int           idx;
        bit           any;
        bit           full;
        bit           empty;
        bit           e_req_val;
        bit           e_mem_resp_rdy;
        bit           req_fire;
        bit           resp_fire;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_resp_val;
        logic [N-1:0] e_grant;
        mem_req_16B_t e_msg;
        logic [RW-1:0] e_resp;

        for (int p = 0; p < N; p++) begin
            if (!pend[p] && req_left[p] > 0 && $urandom_range(99) < gen_pct[p]) begin
                pmsg[p] = rand_req();
                pend[p] = 1;
                req_left[p]--;
            end
            in_req_val[p]  = pend[p];
            in_req_msg[p]  = pend[p] ? pmsg[p] : rand_req();
            in_resp_rdy[p] = ($urandom_range(99) < resp_pct[p]);
        end
        mem_req_rdy = ($urandom_range(99) < mem_rdy_pct);
        if (mq_req.size() > 0 && mq_due[0] <= cyc) begin
            mem_resp_val = 1'b1;
            mem_resp_msg = mem_answer(mq_req[0]);
        end else begin
            mem_resp_val = 1'b0;
            mem_resp_msg = mem_answer(rand_req());
        end
        #1;

        any = (in_req_val != '0);
        g   = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (g < 0 && in_req_val[idx]) g = idx;
        end
        full      = (src_q.size() == MO);
        empty     = (src_q.size() == 0);
        e_req_val = any && !full;
        e_msg     = any ? in_req_msg[g] : '0;
        req_fire  = e_req_val && mem_req_rdy;
        e_rdy     = req_fire ? (N'(1) << g) : '0;
        h         = empty ? 0 : src_q[0];
        e_resp_val     = (!empty && mem_resp_val) ? (N'(1) << h) : '0;
        e_mem_resp_rdy = !empty && in_resp_rdy[h];
        resp_fire      = mem_resp_val && e_mem_resp_rdy;
`ifdef LAB4_SYS_MEM_ARBITER_STATS_EN
        e_grant = req_fire ? (N'(1) << g) : '0;
        chk("stats_conflicts", 192'(stats_conflicts), 192'(m_conf));
`else
        e_grant = '0;
        chk("stats_conflicts", 192'(stats_conflicts), 192'(0));
`endif
        chk("mem_req_val", 192'(mem_req_val), 192'(e_req_val));
        chk("mem_req_msg", 192'(mem_req_msg), 192'(e_msg));
        chk("in_req_rdy", 192'(in_req_rdy), 192'(e_rdy));
        chk("in_resp_val", 192'(in_resp_val), 192'(e_resp_val));
        chk("mem_resp_rdy", 192'(mem_resp_rdy), 192'(e_mem_resp_rdy));
        chk("stats_grant", 192'(stats_grant), 192'(e_grant));

        for (int p = 0; p < N; p++) begin
            if (in_resp_val[p] && in_resp_rdy[p]) dut_resp_cnt[p]++;
            if (in_req_val[p] && in_req_rdy[p]) grant_log.push_back(p);
        end

        if (resp_fire) begin
            if (h == 0 && exp_q0.size() > 0) e_resp = exp_q0.pop_front();
            else if (h == 1 && exp_q1.size() > 0) e_resp = exp_q1.pop_front();
            else e_resp = 'x;
            chk("in_resp_msg", 192'(in_resp_msg[h]), 192'(e_resp));
            void'(src_q.pop_front());
            void'(mq_req.pop_front());
            void'(mq_due.pop_front());
        end
        if (req_fire) begin
            pend[g] = 0;
            src_q.push_back(g);
            mq_req.push_back(in_req_msg[g]);
            mq_due.push_back(cyc + 1 + mem_delay);
            if (g == 0) exp_q0.push_back(mem_answer(in_req_msg[g]));
            else        exp_q1.push_back(mem_answer(in_req_msg[g]));
            m_rr = (g + 1) % N;
        end
        if ($countones(in_req_val) >= 2) m_conf++;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_mem_req_val", 192'(mem_req_val), 192'(0));
        chk("rst_in_req_rdy", 192'(in_req_rdy), 192'(0));
        chk("rst_in_resp_val", 192'(in_resp_val), 192'(0));
        chk("rst_mem_resp_rdy", 192'(mem_resp_rdy), 192'(0));
        chk("rst_stats_grant", 192'(stats_grant), 192'(0));
        @(posedge clk);
        #1;
        cyc++;
        clear_model();
        chk("rst_count", 192'(dut.count), 192'(0));
        chk("rst_rr", 192'(dut.rr), 192'(0));
        chk("rst_conflicts", 192'(stats_conflicts), 192'(0));
        chk("rst_hold_mem_req_val", 192'(mem_req_val), 192'(0));
        chk("rst_hold_mem_resp_rdy", 192'(mem_resp_rdy), 192'(0));
        reset = 1'b1;
    endtask

    task automatic run_to_idle(input int budget);
        int n;
        n = 0;
        while (!idle() && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 192'(idle()), 192'(1));
    endtask

    task automatic set_knobs(input int g0, input int g1, input int r0, input int r1,
                             input int mrdy, input int dly);
        gen_pct[0]  = g0;
        gen_pct[1]  = g1;
        resp_pct[0] = r0;
        resp_pct[1] = r1;
        mem_rdy_pct = mrdy;
        mem_delay   = dly;
    endtask

    initial begin
        reset        = 1'b0;
        in_req_val   = '0;
        in_resp_rdy  = '0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;
        for (int p = 0; p < N; p++) in_req_msg[p] = '0;
        clear_model();
        set_knobs(0, 0, 100, 100, 100, 0);
        @(posedge clk);
        #1;
        do_reset();

        // Single port, four loads, zero-delay memory: all responses return on port 0.
        set_knobs(100, 0, 100, 100, 100, 0);
        req_left[0] = 4;
        dut_resp_cnt[0] = 0;
        dut_resp_cnt[1] = 0;
        run_to_idle(100);
        chk("single_port_resp0", 192'(dut_resp_cnt[0]), 192'(4));
        chk("single_port_resp1", 192'(dut_resp_cnt[1]), 192'(0));

        // Both ports always valid: grants alternate 0,1,0,1,...
        do_reset();
        set_knobs(100, 100, 100, 100, 100, 0);
        req_left[0] = 6;
        req_left[1] = 6;
        grant_log.delete();
        run_to_idle(200);
        chk("rr_grant_count", 192'(grant_log.size()), 192'(12));
        for (int i = 0; i < 12 && i < grant_log.size(); i++)
            chk("rr_grant_order", 192'(grant_log[i]), 192'(i % 2));

        // Slow memory: the FIFO fills and later requests stall until a response drains.
        set_knobs(100, 0, 100, 100, 100, 10);
        req_left[0] = MO + 2;
        run_to_idle(400);

        // Moderate delay on both ports: full cycles coincide with pops.
        set_knobs(100, 100, 100, 100, 100, 3);
        req_left[0] = 8;
        req_left[1] = 8;
        run_to_idle(400);

        // Port 1 stalls its response at the head; port 0's response waits behind it.
        set_knobs(100, 100, 100, 0, 100, 0);
        dut_resp_cnt[0] = 0;
        dut_resp_cnt[1] = 0;
        req_left[1] = 1;
        repeat (2) tick();
        req_left[0] = 1;
        repeat (8) tick();
        chk("hol_port0_blocked", 192'(dut_resp_cnt[0]), 192'(0));
        chk("hol_port1_blocked", 192'(dut_resp_cnt[1]), 192'(0));
        resp_pct[1] = 100;
        run_to_idle(100);
        chk("hol_port0_done", 192'(dut_resp_cnt[0]), 192'(1));
        chk("hol_port1_done", 192'(dut_resp_cnt[1]), 192'(1));

        // Reset with three requests in flight discards them.
        set_knobs(100, 0, 100, 100, 100, 20);
        req_left[0] = 3;
        for (int n = 0; n < 20 && src_q.size() < 3; n++) tick();
        chk("three_outstanding", 192'(dut.count), 192'(3));
        do_reset();
        set_knobs(0, 0, 100, 100, 100, 0);
        repeat (3) tick();

        // Random traffic with shifting knobs, then a clean drain.
        for (int blk = 0; blk < 10; blk++) begin
            set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100, 20),
                      $urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(6));
            req_left[0] += $urandom_range(12);
            req_left[1] += $urandom_range(12);
            repeat (50) tick();
        end
        set_knobs(100, 100, 100, 100, 100, 0);
        run_to_idle(1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
